// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants and types for the ALU issue controller.
// ALU op codes, condition codes, controller FSM state type and the
// default datapath width.
package alu_issue_pkg;

  localparam int WIDTH_DEF = 32;

  // ALU controlBits encoding
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_CMP  = 4'd2;
  localparam logic [3:0] ALU_PASS = 4'd3;
  localparam logic [3:0] ALU_MUL  = 4'd4;
  localparam logic [3:0] ALU_DIV  = 4'd5;
  localparam logic [3:0] ALU_MOD  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOT  = 4'd10;
  localparam logic [3:0] ALU_INC  = 4'd11;
  localparam logic [3:0] ALU_DEC  = 4'd12;
  localparam logic [3:0] ALU_SHR  = 4'd13;
  localparam logic [3:0] ALU_SRA  = 4'd14;
  localparam logic [3:0] ALU_SHL  = 4'd15;

  // Condition codes evaluated against the shadow compare flags
  localparam logic [2:0] CC_AL = 3'd0;
  localparam logic [2:0] CC_EQ = 3'd1;
  localparam logic [2:0] CC_NE = 3'd2;
  localparam logic [2:0] CC_LT = 3'd3;
  localparam logic [2:0] CC_GE = 3'd4;
  localparam logic [2:0] CC_GT = 3'd5;
  localparam logic [2:0] CC_LE = 3'd6;
  localparam logic [2:0] CC_NV = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRIVE    = 2'd1,
    ST_CMP_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  // Ops that divide by their second operand
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_MOD);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_eval.sv
// cond_eval: combinational condition-code check against compare flags.
module cond_eval
  import alu_issue_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic       zr_i,
  input  logic       neg_i,
  output logic       pass_o
);

  // Map each condition code onto the zero/negative flag pair.
  always_comb begin
    pass_o = 1'b0;
    case (cond_i)
      CC_AL:   pass_o = 1'b1;
      CC_EQ:   pass_o = zr_i;
      CC_NE:   pass_o = ~zr_i;
      CC_LT:   pass_o = neg_i;
      CC_GE:   pass_o = ~neg_i;
      CC_GT:   pass_o = ~zr_i & ~neg_i;
      CC_LE:   pass_o = zr_i | neg_i;
      CC_NV:   pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-outstanding issue controller in front of the
// combinational, flag-latching ALU. Accepts a request, checks its
// condition against shadow compare flags, drives the ALU for one cycle,
// and returns the result over a held valid/ready response channel.
// Optional build macro: ALU_ISSUE_DIVZERO_CHK_EN enables the
// divide/modulo-by-zero trap (rsp_err); otherwise rsp_err stays 0.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_op,
  input  logic [2:0]              req_cond,
  input  logic signed [WIDTH-1:0] req_a,
  input  logic signed [WIDTH-1:0] req_b,
  output logic signed [WIDTH-1:0] alu_in1,
  output logic signed [WIDTH-1:0] alu_in2,
  output logic [3:0]              alu_ctrl,
  input  logic signed [WIDTH-1:0] alu_out,
  input  logic                    alu_zr,
  input  logic                    alu_neg,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic signed [WIDTH-1:0] rsp_data,
  output logic                    rsp_exec,
  output logic                    rsp_zr,
  output logic                    rsp_neg,
  output logic                    rsp_err
);

  state_t                  state_q;
  logic                    req_ready_q;
  logic signed [WIDTH-1:0] alu_in1_q;
  logic signed [WIDTH-1:0] alu_in2_q;
  logic [3:0]              alu_ctrl_q;
  logic                    shadow_zr_q;
  logic                    shadow_neg_q;
  logic                    rsp_valid_q;
  logic signed [WIDTH-1:0] rsp_data_q;
  logic                    rsp_exec_q;
  logic                    rsp_err_q;
  logic                    rsp_zr_q;
  logic                    rsp_neg_q;

  logic cond_pass;
  logic is_cmp;
  logic exec_ok;
  logic trap;
  logic accept;

  // Condition check uses only the shadow flags: the ALU flags are unreset.
  cond_eval u_cond_eval (
    .cond_i (req_cond),
    .zr_i   (shadow_zr_q),
    .neg_i  (shadow_neg_q),
    .pass_o (cond_pass)
  );

  // Compares always run regardless of their condition field.
  assign is_cmp  = (req_op == ALU_CMP);
  assign exec_ok = is_cmp | cond_pass;
  // req_ready_q is only ever high in IDLE, so this is an IDLE-only accept.
  assign accept  = req_valid & req_ready_q;

`ifdef ALU_ISSUE_DIVZERO_CHK_EN
  assign trap = is_div_op(req_op) && (req_b == '0);
`else
  assign trap = 1'b0;
`endif

  // Controller FSM: accept, drive ALU, shadow compare flags, hold response.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_ctrl_q   <= ALU_PASS;
      shadow_zr_q  <= 1'b0;
      shadow_neg_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_exec_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_zr_q     <= 1'b0;
      rsp_neg_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            if (!exec_ok || trap) begin
              // Skipped or trapped: answer next cycle, ALU left untouched.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_exec_q  <= 1'b0;
              rsp_err_q   <= exec_ok & trap;
              rsp_zr_q    <= shadow_zr_q;
              rsp_neg_q   <= shadow_neg_q;
            end else begin
              state_q    <= ST_DRIVE;
              alu_in1_q  <= req_a;
              alu_in2_q  <= req_b;
              alu_ctrl_q <= req_op;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        ST_DRIVE: begin
          // Return the ALU to a harmless pass-through after one cycle.
          alu_in1_q  <= '0;
          alu_in2_q  <= '0;
          alu_ctrl_q <= ALU_PASS;
          if (alu_ctrl_q == ALU_CMP) begin
            state_q <= ST_CMP_WAIT;
          end else begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= alu_out;
            rsp_exec_q  <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_zr_q    <= shadow_zr_q;
            rsp_neg_q   <= shadow_neg_q;
          end
        end

        ST_CMP_WAIT: begin
          // ALU latched its flags at the end of DRIVE; copy them now.
          shadow_zr_q  <= alu_zr;
          shadow_neg_q <= alu_neg;
          state_q      <= ST_RESP;
          rsp_valid_q  <= 1'b1;
          rsp_data_q   <= '0;
          rsp_exec_q   <= 1'b1;
          rsp_err_q    <= 1'b0;
          rsp_zr_q     <= alu_zr;
          rsp_neg_q    <= alu_neg;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign alu_in1   = alu_in1_q;
  assign alu_in2   = alu_in2_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_exec  = rsp_exec_q;
  assign rsp_zr    = rsp_zr_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue controller that sits in front of the combinational/flag-latching ALU and acts as its initiator. It accepts one operation request at a time over a valid/ready handshake, evaluates the request's condition code against a shadow copy of the ALU compare flags, and drives the ALU operand and control ports. It then captures the result and returns it over a valid/ready response channel. It owns compare sequencing, so the ALU's clocked zr/neg flags are never disturbed by idle cycles.

## Interface
- WIDTH, 32, operand/result width (signed two's complement)
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; registered
- req_op  in  4  ALU op code 0..15 (2 = compare)
- req_cond  in  3  condition code
- req_a, req_b  in  WIDTH  operands
- alu_in1, alu_in2  out  WIDTH  ALU operands
- alu_ctrl  out  4  ALU controlBits
- alu_out  in  WIDTH  ALU result
- alu_zr, alu_neg  in  1  ALU latched flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WIDTH  result; 0 when not executed
- rsp_exec  out  1  condition passed, result valid
- rsp_zr, rsp_neg  out  1  shadow-flag snapshot at response time
- rsp_err  out  1  divide/modulo-by-zero trap (see Configuration)

## Operation
- FSM states: IDLE, DRIVE, CMP_WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch op, cond, a, b.
  - Condition fails: go to RESP with rsp_exec=0 and rsp_data=0.
  - Trap: go to RESP with rsp_exec=0, rsp_data=0 and rsp_err=1.
  - Otherwise: go to DRIVE.
- Condition codes: 0 AL, 1 EQ (zr), 2 NE (!zr), 3 LT (neg), 4 GE (!neg), 5 GT (!zr&!neg), 6 LE (zr|neg), 7 NV (never).
  - Compare ops (op 2) ignore cond and always execute.
- DRIVE: alu_in1=a, alu_in2=b, alu_ctrl=op.
  - Non-compare: capture alu_out into rsp_data at the edge ending DRIVE, then go to RESP.
  - Compare: the ALU latches its flags at the edge ending DRIVE; go to CMP_WAIT.
- CMP_WAIT: alu_ctrl=3. Sample alu_zr/alu_neg into the shadow flags at the edge ending CMP_WAIT; rsp_data=0, rsp_exec=1; go to RESP.
- RESP: rsp_valid=1 and all rsp_* held stable until rsp_valid&rsp_ready, then go to IDLE.
- Outside DRIVE, alu_ctrl=3 and alu_in1=alu_in2=0. This guarantees the ALU never sees op 2 spuriously.
- Shadow flags change only in CMP_WAIT. They are the sole flag source for condition evaluation, because the ALU flags themselves are unreset.
- Arithmetic is performed entirely by the ALU; the controller does no width extension and passes results unmodified.

## Timing
- Reset (reset_n low at an edge):
  - state=IDLE; req_ready=0, rises the first cycle after release.
  - rsp_valid=0, rsp_data=0, rsp_exec=0, rsp_err=0.
  - Shadow flags and rsp_zr/rsp_neg=0.
  - alu_ctrl=3, alu_in1=alu_in2=0.
- Latency from accept edge to rsp_valid high:
  - condition-fail or trap: 1 cycle
  - normal op: 2 cycles
  - compare: 3 cycles
- Throughput: one request per response handshake. req_ready returns the cycle after the RESP handshake, so there is no overlap.
- Reset mid-operation: the transaction is discarded, no response is produced, and the shadow flags are cleared. A following EQ request therefore fails.
- A response not yet accepted is held indefinitely; req_ready stays 0.

## Configuration
- ALU_ISSUE_DIVZERO_CHK_EN defined: op 5 or 6 with req_b==0 traps. The ALU is not driven, and the response has rsp_err=1, rsp_exec=0, rsp_data=0 at 1-cycle latency.
- Not defined: no check; rsp_err is tied 0 and op 5/6 issue normally.

## Structure
- Package alu_issue_pkg holds:
  - op code constants (ALU_ADD=0 … ALU_SHL=15, ALU_CMP=2, ALU_PASS=3)
  - condition code constants
  - FSM state typedef
  - WIDTH default
- One sub-module, cond_eval: combinational (cond, zr, neg) -> pass.

## Test plan
- ADD 5+7, cond AL -> rsp_valid 2 cycles after accept, rsp_data=12, rsp_exec=1, alu_ctrl=0 for exactly one cycle.
- CMP 3 vs 9 -> rsp at 3 cycles with rsp_zr=0, rsp_neg=1. Then SUB 10-4 cond LT -> data 6, exec 1. Then SUB cond GE -> exec 0, data 0, 1-cycle latency.
- Backpressure: hold rsp_ready=0 for 4 cycles after an ADD response -> rsp_* stable, req_ready=0, alu_ctrl=3 throughout.
- Assert reset_n low during CMP_WAIT -> rsp_valid=0, no response; next EQ request -> exec 0.
- DIV 7/0 with the macro -> rsp_err=1, data 0, latency 1, alu_ctrl never 5. Without the macro -> alu_ctrl=5 for one cycle and rsp_err=0.
- Back-to-back with req_valid held high: MUL -6*7 then ADD -42+42 -> data -42 then 0. The second request is accepted the cycle after the first response handshake.
